// File: rtl/decodificador_varredura.sv
// decodificador_varredura: registered N-to-2^N one-hot decoder with enable,
// a loadable index register and an auto-scan mode that walks the active
// output across all lines at a programmable rate (display digit / row scan).
//
// Ports:
//   clk   - clock, all state updates on the rising edge
//   rst   - synchronous active-high reset
//   A     - index to load (N bits)
//   E     - enable; 0 forces S inactive and freezes scanning
//   load  - load A into the index register (wins over a scan step)
//   mode  - 0 = direct, 1 = scan
//   S     - registered one-hot decode of idx (inverted when ACTIVE_LOW=1)
//   idx   - current index register
//   wrap  - one-cycle pulse when a scan step wraps idx from 2^N-1 to 0
module decodificador_varredura #(
  parameter int unsigned N          = 3,
  parameter int unsigned DIV        = 4,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      A,
  input  logic              E,
  input  logic              load,
  input  logic              mode,
  output logic [(1<<N)-1:0] S,
  output logic [N-1:0]      idx,
  output logic              wrap
);

  localparam int unsigned W  = 1 << N;
  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [N-1:0]  idx_q, idx_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [W-1:0]  s_q, s_d;
  logic          wrap_q, wrap_d;
  logic          tick_c;
  logic [W-1:0]  onehot_c;

  // Scan step strobe; a simultaneous load suppresses it.
  assign tick_c = mode & E & (pcnt_q == PW'(DIV - 1)) & ~load;

  // Next-state computation for index, prescaler, wrap pulse and decode.
  always_comb begin
    idx_d    = idx_q;
    pcnt_d   = pcnt_q;
    wrap_d   = 1'b0;
    onehot_c = '0;

    if (load) begin
      idx_d = A;
    end else if (tick_c) begin
      idx_d = idx_q + N'(1);
    end

    // Prescaler clears on load or in direct mode, holds while disabled.
    if (load || !mode) begin
      pcnt_d = '0;
    end else if (E) begin
      pcnt_d = tick_c ? '0 : pcnt_q + PW'(1);
    end

    wrap_d = tick_c & (idx_q == {N{1'b1}});

    // Decode the new index so S and idx always change on the same edge.
    if (E) begin
      onehot_c = W'(1) << idx_d;
    end
    s_d = ACTIVE_LOW ? ~onehot_c : onehot_c;
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      pcnt_q <= '0;
      wrap_q <= 1'b0;
      s_q    <= ACTIVE_LOW ? {W{1'b1}} : {W{1'b0}};
    end else begin
      idx_q  <= idx_d;
      pcnt_q <= pcnt_d;
      wrap_q <= wrap_d;
      s_q    <= s_d;
    end
  end

  assign S    = s_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_decodificador_varredura.sv
// Bench for decodificador_varredura: three builds (N=3/DIV=4, N=2/DIV=1,
// N=3/DIV=4 active-low) share one stimulus stream; a behavioural model
// predicts every output each cycle, and literal checks pin key points.
module tb_decodificador_varredura;

  logic       clk = 1'b0;
  logic       rst, E, load, mode;
  logic [2:0] A;
  logic [1:0] a2;

  logic [7:0] s0, s2;
  logic [3:0] s1;
  logic [2:0] idx0, idx2;
  logic [1:0] idx1;
  logic       wrap0, wrap1, wrap2;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  assign a2 = A[1:0];

  always #5 clk = ~clk;

  decodificador_varredura #(.N(3), .DIV(4), .ACTIVE_LOW(1'b0)) u0 (
    .clk(clk), .rst(rst), .A(A), .E(E), .load(load), .mode(mode),
    .S(s0), .idx(idx0), .wrap(wrap0));

  decodificador_varredura #(.N(2), .DIV(1), .ACTIVE_LOW(1'b0)) u1 (
    .clk(clk), .rst(rst), .A(a2), .E(E), .load(load), .mode(mode),
    .S(s1), .idx(idx1), .wrap(wrap1));

  decodificador_varredura #(.N(3), .DIV(4), .ACTIVE_LOW(1'b1)) u2 (
    .clk(clk), .rst(rst), .A(A), .E(E), .load(load), .mode(mode),
    .S(s2), .idx(idx2), .wrap(wrap2));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: index as an integer modulo 2^n, a cycle counter
  // toward the next step, and whether E was high at the last edge.
  int m_n[3]   = '{3, 2, 3};
  int m_div[3] = '{4, 1, 4};
  int m_al[3]  = '{0, 0, 1};
  int m_idx[3], m_cnt[3], m_wrap[3], m_en[3];

  function automatic logic [31:0] exp_s(input int k);
    int sz;
    logic [31:0] mask, v;
    sz   = 1 << m_n[k];
    mask = 32'((64'd1 << sz) - 1);
    v    = (m_en[k] != 0) ? (32'd1 << m_idx[k]) : 32'd0;
    return (m_al[k] != 0) ? (v ^ mask) : v;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      int sz;
      bit step;
      sz = 1 << m_n[k];
      if (rst) begin
        m_idx[k] = 0; m_cnt[k] = 0; m_wrap[k] = 0; m_en[k] = 0;
      end else begin
        step = mode && E && !load && (m_cnt[k] == m_div[k] - 1);
        m_wrap[k] = (step && m_idx[k] == sz - 1) ? 1 : 0;
        if (load) m_idx[k] = int'(A) % sz;
        else if (step) m_idx[k] = (m_idx[k] + 1) % sz;
        if (load || !mode) m_cnt[k] = 0;
        else if (E) m_cnt[k] = step ? 0 : m_cnt[k] + 1;
        m_en[k] = E ? 1 : 0;
      end
    end
    #1;
    if (chk_en) begin
      chk("m0.S", 32'(s0), exp_s(0));
      chk("m0.idx", 32'(idx0), 32'(m_idx[0]));
      chk("m0.wrap", 32'(wrap0), 32'(m_wrap[0]));
      chk("m1.S", 32'(s1), exp_s(1));
      chk("m1.idx", 32'(idx1), 32'(m_idx[1]));
      chk("m1.wrap", 32'(wrap1), 32'(m_wrap[1]));
      chk("m2.S", 32'(s2), exp_s(2));
      chk("m2.idx", 32'(idx2), 32'(m_idx[2]));
      chk("m2.wrap", 32'(wrap2), 32'(m_wrap[2]));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; E = 1'b1; mode = 1'b1; load = 1'b0; A = 3'd0;
    @(negedge clk);
    cyc(2);
    chk_en = 1'b1;
    chk("rst.S0", 32'(s0), 32'h00);
    chk("rst.idx0", 32'(idx0), 32'd0);
    chk("rst.wrap0", 32'(wrap0), 32'd0);
    chk("rst.S2_al", 32'(s2), 32'hFF);
    chk("rst.S1", 32'(s1), 32'h0);

    // Direct decode
    rst = 1'b0; mode = 1'b0; E = 1'b1;
    for (int a = 0; a < 8; a++) begin
      load = 1'b1; A = 3'(a);
      cyc(1);
      chk("direct.S0", 32'(s0), 32'd1 << a);
      chk("direct.idx0", 32'(idx0), 32'(a));
    end
    load = 1'b0; E = 1'b0;
    cyc(1);
    chk("disable.S0", 32'(s0), 32'h00);
    chk("disable.idx0", 32'(idx0), 32'd7);
    chk("disable.S2_al", 32'(s2), 32'hFF);

    // Scan from idx=0: full sweep of 32 cycles at DIV=4
    E = 1'b1; mode = 1'b1; load = 1'b1; A = 3'd0;
    cyc(1);
    load = 1'b0;
    cyc(3);
    chk("scan.hold3", 32'(idx0), 32'd0);
    cyc(1);
    chk("scan.step4", 32'(idx0), 32'd1);
    chk("scan.S4", 32'(s0), 32'h02);
    cyc(27);
    chk("scan.idx31", 32'(idx0), 32'd7);
    chk("scan.nowrap31", 32'(wrap0), 32'd0);
    cyc(1);
    chk("scan.idx32", 32'(idx0), 32'd0);
    chk("scan.wrap32", 32'(wrap0), 32'd1);
    chk("scan.S32", 32'(s0), 32'h01);
    cyc(1);
    chk("scan.wrap33", 32'(wrap0), 32'd0);

    // Freeze at idx=3, pcnt=2
    cyc(13);
    chk("frz.idx", 32'(idx0), 32'd3);
    E = 1'b0;
    cyc(5);
    chk("frz.S", 32'(s0), 32'h00);
    chk("frz.idx_held", 32'(idx0), 32'd3);
    E = 1'b1;
    cyc(1);
    chk("resume.S1", 32'(s0), 32'h08);
    cyc(1);
    chk("resume.idx", 32'(idx0), 32'd4);
    chk("resume.S", 32'(s0), 32'h10);

    // Load against a would-be tick at idx=7
    cyc(15);
    chk("lvt.pre_idx", 32'(idx0), 32'd7);
    load = 1'b1; A = 3'd6;
    cyc(1);
    load = 1'b0;
    chk("lvt.idx", 32'(idx0), 32'd6);
    chk("lvt.S", 32'(s0), 32'h40);
    chk("lvt.nowrap", 32'(wrap0), 32'd0);
    chk("lvt.S_al", 32'(s2), 32'hBF);
    cyc(3);
    chk("lvt.hold", 32'(idx0), 32'd6);
    cyc(1);
    chk("lvt.step", 32'(idx0), 32'd7);

    // Reset mid-sweep, then DIV=1 scan on the N=2 build
    rst = 1'b1;
    cyc(1);
    chk("rst2.idx1", 32'(idx1), 32'd0);
    chk("rst2.S1", 32'(s1), 32'h0);
    chk("rst2.S0", 32'(s0), 32'h00);
    rst = 1'b0;
    cyc(1);
    chk("d1.S_c1", 32'(s1), 32'h2);
    cyc(2);
    chk("d1.S_c3", 32'(s1), 32'h8);
    chk("d1.nowrap", 32'(wrap1), 32'd0);
    cyc(1);
    chk("d1.idx_c4", 32'(idx1), 32'd0);
    chk("d1.wrap_c4", 32'(wrap1), 32'd1);
    chk("d1.S_c4", 32'(s1), 32'h1);

    // Mixed directed/pseudo-random traffic, checked by the model
    for (int i = 0; i < 400; i++) begin
      rst  = ($urandom_range(0, 59) == 0);
      E    = ($urandom_range(0, 3) != 0);
      mode = ($urandom_range(0, 7) != 0);
      load = ($urandom_range(0, 9) == 0);
      A    = 3'($urandom_range(0, 7));
      cyc(1);
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
